// File: rtl/pipe_reg_fde_if.sv
// Handshake bundle for the elastic pipeline register.
// The master side produces upstream words and consumes downstream words.
// The slave side is the pipeline register itself.
interface pipe_reg_fde_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_fde.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit data, each with its own valid bit.
// An empty stage always accepts, so bubbles collapse under backpressure.
// i_enable=0 synchronously clears every stage.
// Optional feature macro: PIPE_REG_OCCUPANCY_EN adds the o_occupancy valid-stage counter.
module pipe_reg_fde #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enable,
`ifdef PIPE_REG_OCCUPANCY_EN
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
`endif
  pipe_reg_fde_if.slave              bus
);

  generate
    if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
      $error("pipe_reg_fde: WIDTH and DEPTH must both be >= 1");
    end
  endgenerate

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d    [DEPTH];
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_srcV;
  logic [WIDTH-1:0] w_srcD [DEPTH];

  // Stage 0 is fed from the upstream port; every later stage is fed from its predecessor.
  assign w_srcV[0] = bus.in_valid;
  assign w_srcD[0] = bus.in_data;
  genvar g;
  generate
    for (g = 1; g < DEPTH; g++) begin : g_src
      assign w_srcV[g] = r_v[g-1];
      assign w_srcD[g] = r_d[g-1];
    end
  endgenerate

  // A stage may advance when it is empty or when everything downstream of it moves.
  always_comb begin
    logic a;
    w_adv = '0;
    a = bus.out_ready | ~r_v[DEPTH-1];
    w_adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a = a | ~r_v[i];
      w_adv[i] = a;
    end
  end

  assign bus.in_ready  = w_adv[0] & i_enable;
  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out_data  = r_d[DEPTH-1];

  // Stage registers: clear on reset or !enable, otherwise load from the source when advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else if (!i_enable) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= w_srcV[i];
          if (w_srcV[i]) r_d[i] <= w_srcD[i];
        end
      end
    end
  end

`ifdef PIPE_REG_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             w_inFire;
  logic             w_outFire;
  logic [OCC_W-1:0] r_occupancy;

  assign w_inFire    = bus.in_valid & bus.in_ready;
  assign w_outFire   = bus.out_valid & bus.out_ready;
  assign o_occupancy = r_occupancy;

  // Running count of valid stages, tracking words in minus words out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occupancy <= '0;
    end else if (!i_enable) begin
      r_occupancy <= '0;
    end else begin
      r_occupancy <= r_occupancy + OCC_W'(w_inFire) - OCC_W'(w_outFire);
    end
  end
`endif

endmodule
